// File: rtl/riscv_v_sign_restore.sv
// Restores the result sign after an unsigned multiply/divide datapath. Sign tags are
// queued in order at issue and popped as the magnitude results come back.

module riscv_v_sign_restore_lane #(
  parameter int NUM_OSIZES = 4
) (
  input  logic [63:0]           in_data,
  input  logic [7:0]            neg,
  input  logic [NUM_OSIZES-1:0] osize,
  output logic [63:0]           out_data
);
  localparam int NS = (NUM_OSIZES < 4) ? NUM_OSIZES : 4;

  logic [3:0][63:0] cand;

  // One candidate per element width; each carry chain stops at its element boundary
  for (genvar k = 0; k < 4; k++) begin : g_size
    localparam int W  = 8 << k;
    localparam int NE = 64 / W;
    for (genvar e = 0; e < NE; e++) begin : g_elem
      logic [W-1:0] x;
      assign x = in_data[e*W +: W];
      assign cand[k][e*W +: W] = neg[e*(W/8)] ? (~x + W'(1)) : x;
    end
  end

  // Walking down from the widest size lets the lowest set osize bit win
  always_comb begin
    out_data = in_data;
    for (int i = NS - 1; i >= 0; i--) begin
      if (osize[i]) out_data = cand[i];
    end
  end
endmodule

module riscv_v_sign_restore #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_BYTES  = DATA_WIDTH / 8,
  parameter int NUM_OSIZES = 4,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tag_valid,
  output logic                         tag_ready,
  input  logic [NUM_BYTES-1:0]         tag_neg,
  input  logic [NUM_OSIZES-1:0]        tag_osize,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [DATA_WIDTH-1:0]        res_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(TAG_DEPTH):0]   tag_count
);
  localparam int NUM_LANES = DATA_WIDTH / 64;
  localparam int PW        = $clog2(TAG_DEPTH);
  localparam int CW        = PW + 1;

  typedef struct packed {
    logic [NUM_BYTES-1:0]  neg;
    logic [NUM_OSIZES-1:0] osize;
  } tag_t;

  tag_t [TAG_DEPTH-1:0]    mem_q, mem_d;
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    push, pop;
  tag_t                    head;

  logic [NUM_LANES-1:0][63:0] lane_in, lane_out;

  assign head      = mem_q[rptr_q];
  assign tag_ready = (cnt_q != CW'(TAG_DEPTH));
  assign res_ready = (cnt_q != '0) && (!out_valid_q || out_ready);
  assign push      = tag_valid && tag_ready;
  assign pop       = res_valid && res_ready;
  assign lane_in   = res_data;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    riscv_v_sign_restore_lane #(.NUM_OSIZES(NUM_OSIZES)) u_lane (
      .in_data  (lane_in[l]),
      .neg      (head.neg[l*8 +: 8]),
      .osize    (head.osize),
      .out_data (lane_out[l])
    );
  end

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (push) begin
      mem_d[wptr_q] = '{neg: tag_neg, osize: tag_osize};
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d      = rptr_q + PW'(1);
      out_valid_d = 1'b1;
      out_data_d  = lane_out;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign tag_count = cnt_q;
endmodule

// File: tb/tb_riscv_v_sign_restore.sv
// Directed bench for riscv_v_sign_restore with hand-computed expected results.

module tb_riscv_v_sign_restore;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         tag_valid, tag_ready;
  logic [15:0]  tag_neg;
  logic [3:0]   tag_osize;
  logic         res_valid, res_ready;
  logic [127:0] res_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic [2:0]   tag_count;

  int tests = 0;
  int fails = 0;

  riscv_v_sign_restore #(.DATA_WIDTH(128), .NUM_OSIZES(4), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_neg(tag_neg), .tag_osize(tag_osize),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tag_count(tag_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tag(input logic [15:0] neg, input logic [3:0] osize);
    tag_valid = 1'b1; tag_neg = neg; tag_osize = osize;
    step();
    tag_valid = 1'b0;
  endtask

  task automatic send_res(input logic [127:0] d);
    res_valid = 1'b1; res_data = d;
    step();
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if (tag_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", tag_count); end
    tests++; if (tag_ready !== 1'b1) begin fails++; $display("FAIL reset_tag_ready got %b exp 1", tag_ready); end
    tests++; if (out_valid !== 1'b0 || out_data !== 128'h0) begin fails++; $display("FAIL reset_out got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
    tests++; if (res_ready !== 1'b0) begin fails++; $display("FAIL reset_res_ready got %b exp 0", res_ready); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_neg8();
    logic [127:0] exp;
    out_ready = 1'b1;
    push_tag(16'h0001, 4'b0001);
    tests++; if (tag_count !== 3'd1) begin fails++; $display("FAIL neg8_count_push got %0d exp 1", tag_count); end
    exp = {{15{8'h11}}, 8'hFB};
    send_res({{15{8'h11}}, 8'h05});
    tests++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++; $display("FAIL neg8_data got v=%b %h exp %h", out_valid, out_data, exp); end
    tests++; if (tag_count !== 3'd0) begin fails++; $display("FAIL neg8_count_pop got %0d exp 0", tag_count); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL neg8_valid_clear got %b exp 0", out_valid); end
    // minimum value and zero negate to themselves
    push_tag(16'h0003, 4'b0001);
    send_res(128'h0000_0080);
    tests++; if (out_data !== 128'h0000_0080) begin fails++; $display("FAIL neg8_min got %h exp %h", out_data, 128'h80); end
    step();
  endtask

  task automatic test_neg16();
    push_tag(16'h0005, 4'b0010);
    send_res(128'h0000_0001);
    tests++; if (out_data !== 128'h0000_FFFF) begin fails++; $display("FAIL neg16_data got %h exp %h", out_data, 128'h0000_FFFF); end
    // neg bits on odd bytes only must not affect 16b elements
    push_tag(16'h000A, 4'b0010);
    send_res(128'h0003_0001);
    tests++; if (out_data !== 128'h0003_0001) begin fails++; $display("FAIL neg16_ignore got %h exp %h", out_data, 128'h0003_0001); end
    step();
  endtask

  task automatic test_neg64();
    push_tag(16'h0101, 4'b1000);
    send_res({64'h8000_0000_0000_0000, 64'h0});
    tests++; if (out_data !== {64'h8000_0000_0000_0000, 64'h0}) begin fails++; $display("FAIL neg64_min got %h exp %h", out_data, {64'h8000_0000_0000_0000, 64'h0}); end
    push_tag(16'h0001, 4'b1000);
    send_res({64'h1, 64'h1});
    tests++; if (out_data !== {64'h1, 64'hFFFF_FFFF_FFFF_FFFF}) begin fails++; $display("FAIL neg64_nocarry got %h exp %h", out_data, {64'h1, 64'hFFFF_FFFF_FFFF_FFFF}); end
    step();
  endtask

  task automatic test_osize_edge();
    push_tag(16'hFFFF, 4'b0000);
    send_res(128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978);
    tests++; if (out_data !== 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978) begin fails++; $display("FAIL osize_zero got %h exp passthrough", out_data); end
    push_tag(16'h0001, 4'b1010);
    send_res(128'h0000_0001);
    tests++; if (out_data !== 128'h0000_FFFF) begin fails++; $display("FAIL osize_multihot got %h exp %h", out_data, 128'h0000_FFFF); end
    step();
  endtask

  task automatic test_full_wrap();
    logic [7:0] exp_b [5];
    exp_b = '{8'hFF, 8'h02, 8'hFD, 8'h04, 8'hFB};
    push_tag(16'h0001, 4'b0001);
    push_tag(16'h0000, 4'b0001);
    push_tag(16'h0001, 4'b0001);
    push_tag(16'h0000, 4'b0001);
    tests++; if (tag_count !== 3'd4 || tag_ready !== 1'b0) begin fails++; $display("FAIL full_state got cnt=%0d rdy=%b exp cnt=4 rdy=0", tag_count, tag_ready); end
    tag_valid = 1'b1; tag_neg = 16'h0001; tag_osize = 4'b0001;
    step();
    tests++; if (tag_count !== 3'd4) begin fails++; $display("FAIL full_hold got %0d exp 4", tag_count); end
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1; res_data = {{15{8'h00}}, 8'(i + 1)};
      step();
      if (i == 1) tag_valid = 1'b0;
      tests++; if (out_valid !== 1'b1 || out_data !== {120'h0, exp_b[i]}) begin fails++; $display("FAIL b2b_%0d got v=%b %h exp %h", i, out_valid, out_data, exp_b[i]); end
      tests++; if (tag_count !== ((i < 2) ? 3'd3 : 3'(4 - i))) begin fails++; $display("FAIL b2b_count_%0d got %0d", i, tag_count); end
    end
    res_valid = 1'b0;
    step();
  endtask

  task automatic test_empty();
    res_valid = 1'b1; res_data = 128'h0000_0007;
    #1;
    tests++; if (res_ready !== 1'b0) begin fails++; $display("FAIL empty_res_ready got %b exp 0", res_ready); end
    tag_valid = 1'b1; tag_neg = 16'h0001; tag_osize = 4'b0001;
    #1;
    tests++; if (res_ready !== 1'b0) begin fails++; $display("FAIL empty_nobypass got %b exp 0", res_ready); end
    step();
    tag_valid = 1'b0;
    tests++; if (res_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL empty_after_push got rdy=%b v=%b exp rdy=1 v=0", res_ready, out_valid); end
    step();
    res_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 128'h0000_00F9) begin fails++; $display("FAIL empty_result got %h exp %h", out_data, 128'hF9); end
    step();
  endtask

  task automatic test_stall_reset();
    push_tag(16'h0001, 4'b0001);
    push_tag(16'h0001, 4'b0001);
    out_ready = 1'b0;
    send_res({{15{8'h11}}, 8'h05});
    res_valid = 1'b1; res_data = 128'h0000_0009;
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_valid !== 1'b1 || out_data !== {{15{8'h11}}, 8'hFB} || res_ready !== 1'b0) begin fails++; $display("FAIL stall_%0d got v=%b rdy=%b %h", i, out_valid, res_ready, out_data); end
      tests++; if (tag_count !== 3'd1) begin fails++; $display("FAIL stall_count_%0d got %0d exp 1", i, tag_count); end
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 128'h0) begin fails++; $display("FAIL async_rst_out got v=%b %h exp 0", out_valid, out_data); end
    tests++; if (tag_count !== 3'd0 || tag_ready !== 1'b1) begin fails++; $display("FAIL async_rst_fifo got cnt=%0d rdy=%b exp 0/1", tag_count, tag_ready); end
    res_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    step();
    tests++; if (res_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL post_rst got rdy=%b v=%b exp 0/0", res_ready, out_valid); end
  endtask

  initial begin
    tag_valid = 1'b0; tag_neg = '0; tag_osize = '0;
    res_valid = 1'b0; res_data = '0; out_ready = 1'b1;
    test_reset();
    test_neg8();
    test_neg16();
    test_neg64();
    test_osize_edge();
    test_full_wrap();
    test_empty();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
